// File: rtl/trace_capture_buffer.sv
// Debug trace unit: logs watched register-file writebacks with PC and cycle stamp
// into a circular buffer drained through a first-word-fall-through read port.
module trace_capture_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   mode,
  input  logic                   trig_en,
  input  logic [DATA_W-1:0]      trig_pc,
  input  logic [2**ADDR_W-1:0]   watch_mask,
  input  logic                   commit_valid,
  input  logic [DATA_W-1:0]      pc,
  input  logic                   reg_we,
  input  logic [ADDR_W-1:0]      reg_waddr,
  input  logic [DATA_W-1:0]      reg_wdata,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [CNT_W-1:0]       rd_stamp,
  output logic [DATA_W-1:0]      rd_pc,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             state,
  output logic [CNT_W-1:0]       dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_next;
  logic [CNT_W-1:0]  r_stamp;
  logic [CNT_W-1:0]  r_dropped;

  logic [CNT_W-1:0]  r_mem_stamp [DEPTH];
  logic [DATA_W-1:0] r_mem_pc    [DEPTH];
  logic [ADDR_W-1:0] r_mem_addr  [DEPTH];
  logic [DATA_W-1:0] r_mem_data  [DEPTH];

  logic w_qe;
  logic w_trig_hit;
  logic w_full;
  logic w_empty;
  logic w_flush;
  logic w_cap_window;
  logic w_stamp_run;
  logic w_pop;
  logic w_push;
  logic w_overwrite;
  logic w_fills;

  // $zero is hardwired, so its writes are never worth logging.
  assign w_qe       = commit_valid & reg_we & (reg_waddr != '0) & watch_mask[reg_waddr];
  assign w_trig_hit = commit_valid & (pc == trig_pc);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);

  // Read handshake: an entry transfers on any edge where rd_valid & rd_ready;
  // rd_valid never depends on rd_ready. A flush discards a concurrent pop.
  assign w_pop       = ~w_empty & rd_ready & ~w_flush;
  assign w_push      = w_qe & w_cap_window & ~(w_full & ~w_pop & mode);
  assign w_overwrite = w_push & w_full & ~w_pop;
  assign w_fills     = w_push & mode & (w_count_next == CW'(DEPTH));

  always_comb begin
    w_count_next = r_count;
    if (w_push & ~w_pop & ~w_full)
      w_count_next = r_count + 1'b1;
    else if (w_pop & ~w_push)
      w_count_next = r_count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (arm) w_state_next = trig_en ? S_ARMED : S_CAPTURE;
      S_ARMED: begin
        if (stop)            w_state_next = S_DONE;
        else if (w_trig_hit) w_state_next = S_CAPTURE;
      end
      S_CAPTURE: if (stop) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
    if (w_fills) w_state_next = S_DONE;
  end

  // Stop beats a trigger arriving in the same cycle, so nothing is captured then.
  always_comb begin
    w_flush      = 1'b0;
    w_cap_window = 1'b0;
    w_stamp_run  = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: w_flush = arm;
      S_ARMED: begin
        w_stamp_run  = 1'b1;
        w_cap_window = w_trig_hit & ~stop;
      end
      S_CAPTURE: begin
        w_stamp_run  = 1'b1;
        w_cap_window = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_stamp   <= '0;
      r_dropped <= '0;
    end else if (w_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_stamp   <= '0;
      r_dropped <= '0;
    end else begin
      if (w_push)               r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop | w_overwrite)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      if (w_stamp_run)          r_stamp <= r_stamp + 1'b1;
      if (w_overwrite && (r_dropped != '1))
        r_dropped <= r_dropped + 1'b1;
    end
  end

  // Storage is not reset; contents are meaningless until count says otherwise.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_stamp[r_wr_ptr] <= r_stamp;
      r_mem_pc[r_wr_ptr]    <= pc;
      r_mem_addr[r_wr_ptr]  <= reg_waddr;
      r_mem_data[r_wr_ptr]  <= reg_wdata;
    end
  end

  assign rd_valid = ~w_empty;
  assign rd_stamp = r_mem_stamp[r_rd_ptr];
  assign rd_pc    = r_mem_pc[r_rd_ptr];
  assign rd_addr  = r_mem_addr[r_rd_ptr];
  assign rd_data  = r_mem_data[r_rd_ptr];
  assign count    = r_count;
  assign state    = r_state;
  assign dropped  = r_dropped;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Bench for trace_capture_buffer (DEPTH=4): directed scenarios plus a random run,
// all checked against a queue-based transaction model of the capture rules.
module tb_trace_capture_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int EW     = CNT_W + DATA_W + ADDR_W + DATA_W;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 arm = 1'b0;
  logic                 stop = 1'b0;
  logic                 mode = 1'b0;
  logic                 trig_en = 1'b0;
  logic [DATA_W-1:0]    trig_pc = '0;
  logic [2**ADDR_W-1:0] watch_mask = '0;
  logic                 commit_valid = 1'b0;
  logic [DATA_W-1:0]    pc = '0;
  logic                 reg_we = 1'b0;
  logic [ADDR_W-1:0]    reg_waddr = '0;
  logic [DATA_W-1:0]    reg_wdata = '0;
  logic                 rd_ready = 1'b0;
  logic                 rd_valid;
  logic [CNT_W-1:0]     rd_stamp;
  logic [DATA_W-1:0]    rd_pc;
  logic [ADDR_W-1:0]    rd_addr;
  logic [DATA_W-1:0]    rd_data;
  logic [CW-1:0]        count;
  logic [1:0]           state;
  logic [CNT_W-1:0]     dropped;

  trace_capture_buffer #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .stop(stop), .mode(mode),
    .trig_en(trig_en), .trig_pc(trig_pc), .watch_mask(watch_mask),
    .commit_valid(commit_valid), .pc(pc), .reg_we(reg_we),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_stamp(rd_stamp),
    .rd_pc(rd_pc), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .state(state), .dropped(dropped)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Entries are {stamp, pc, addr, data}; state 0..3 = IDLE/ARMED/CAPTURE/DONE.
  logic [EW-1:0]    exp_q[$];
  int               m_state = 0;
  logic [CNT_W-1:0] m_stamp = '0;
  logic [CNT_W-1:0] m_dropped = '0;
  int               checks = 0;
  int               errors = 0;

  task automatic model_clear();
    exp_q.delete();
    m_state   = 0;
    m_stamp   = '0;
    m_dropped = '0;
  endtask

  // One clock edge's worth of the capture rules, using the inputs as driven now.
  task automatic model_step();
    int old_state;
    bit qe, hit, cap, pop, push;
    old_state = m_state;
    qe = commit_valid && reg_we && (reg_waddr != 0) && watch_mask[reg_waddr];
    if (arm && (m_state == 0 || m_state == 3)) begin
      exp_q.delete();
      m_stamp   = '0;
      m_dropped = '0;
      m_state   = trig_en ? 1 : 2;
      return;
    end
    hit  = (m_state == 1) && commit_valid && (pc == trig_pc) && !stop;
    cap  = (m_state == 2) || hit;
    pop  = (exp_q.size() > 0) && rd_ready;
    push = qe && cap;
    if (pop) void'(exp_q.pop_front());
    if (push && exp_q.size() == DEPTH) begin
      if (mode) push = 0;
      else begin
        void'(exp_q.pop_front());
        if (m_dropped != '1) m_dropped = m_dropped + 1'b1;
      end
    end
    if (push) exp_q.push_back({m_stamp, pc, reg_waddr, reg_wdata});
    if ((m_state == 1 || m_state == 2) && stop) m_state = 3;
    else if (hit) m_state = 2;
    if (push && mode && exp_q.size() == DEPTH) m_state = 3;
    if (old_state == 1 || old_state == 2) m_stamp = m_stamp + 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [DATA_W-1:0] p);
    commit_valid = 1'b1;
    reg_we       = 1'b1;
    reg_waddr    = a;
    reg_wdata    = d;
    pc           = p;
    tick();
    commit_valid = 1'b0;
    reg_we       = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (dropped !== '0) begin errors++; $display("FAIL reset_dropped got %0d want 0", dropped); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_immediate();
    logic [CNT_W-1:0] first_stamp;
    mode = 1'b0; trig_en = 1'b0; watch_mask = 32'h0003_0000; rd_ready = 1'b0;
    pulse_arm();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL imm_state got %0d want 2", state); end
    commit(5'd16, 32'h5, 32'h100);
    commit(5'd8,  32'h9, 32'h104);
    commit(5'd17, 32'hA, 32'h108);
    checks++; if (count !== CW'(2)) begin errors++; $display("FAIL imm_count got %0d want 2", count); end
    checks++; if (rd_addr !== 5'd16 || rd_data !== 32'h5) begin
      errors++; $display("FAIL imm_head0 got r%0d=%h want r16=5", rd_addr, rd_data); end
    checks++; if ({rd_stamp, rd_pc, rd_addr, rd_data} !== exp_q[0]) begin
      errors++; $display("FAIL imm_entry0 got %h want %h", {rd_stamp, rd_pc, rd_addr, rd_data}, exp_q[0]); end
    first_stamp = rd_stamp;
    pop_one();
    checks++; if (rd_valid !== 1'b1 || rd_addr !== 5'd17 || rd_data !== 32'hA) begin
      errors++; $display("FAIL imm_head1 got v%b r%0d=%h want v1 r17=a", rd_valid, rd_addr, rd_data); end
    checks++; if (!(rd_stamp > first_stamp)) begin
      errors++; $display("FAIL imm_stamp_order got %0d want > %0d", rd_stamp, first_stamp); end
    checks++; if ({rd_stamp, rd_pc, rd_addr, rd_data} !== exp_q[0]) begin
      errors++; $display("FAIL imm_entry1 got %h want %h", {rd_stamp, rd_pc, rd_addr, rd_data}, exp_q[0]); end
    pop_one();
    checks++; if (rd_valid !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL imm_drained got v%b c%0d want v0 c0", rd_valid, count); end
  endtask

  task automatic test_trigger();
    pulse_stop();
    trig_en = 1'b1; trig_pc = 32'h10; watch_mask = '1;
    pulse_arm();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL trig_armed got %0d want 1", state); end
    commit(5'd3, 32'h11, 32'h4);
    commit(5'd3, 32'h22, 32'h8);
    checks++; if (state !== 2'd1 || count !== '0) begin
      errors++; $display("FAIL trig_pre got s%0d c%0d want s1 c0", state, count); end
    commit(5'd3, 32'h33, 32'h10);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL trig_capture got %0d want 2", state); end
    checks++; if (count !== CW'(1) || rd_pc !== 32'h10 || rd_data !== 32'h33) begin
      errors++; $display("FAIL trig_entry got c%0d pc%h d%h want c1 pc10 d33", count, rd_pc, rd_data); end
    checks++; if ({rd_stamp, rd_pc, rd_addr, rd_data} !== exp_q[0]) begin
      errors++; $display("FAIL trig_model got %h want %h", {rd_stamp, rd_pc, rd_addr, rd_data}, exp_q[0]); end
    trig_en = 1'b0;
  endtask

  task automatic test_wrap();
    pulse_stop();
    mode = 1'b0; watch_mask = '1; rd_ready = 1'b0;
    pulse_arm();
    for (int i = 1; i <= 6; i++) commit(5'd5, DATA_W'(i), DATA_W'(32'h200 + 4 * i));
    checks++; if (count !== CW'(4)) begin errors++; $display("FAIL wrap_count got %0d want 4", count); end
    checks++; if (dropped !== CNT_W'(2)) begin errors++; $display("FAIL wrap_dropped got %0d want 2", dropped); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rd_valid !== 1'b1 || rd_data !== DATA_W'(3 + k)) begin
        errors++; $display("FAIL wrap_drain%0d got v%b d%0d want v1 d%0d", k, rd_valid, rd_data, 3 + k); end
      checks++; if ({rd_stamp, rd_pc, rd_addr, rd_data} !== exp_q[0]) begin
        errors++; $display("FAIL wrap_model%0d got %h want %h", k, {rd_stamp, rd_pc, rd_addr, rd_data}, exp_q[0]); end
      pop_one();
    end
    checks++; if (count !== '0) begin errors++; $display("FAIL wrap_empty got %0d want 0", count); end
  endtask

  task automatic test_stop_full();
    pulse_stop();
    mode = 1'b1; watch_mask = '1; rd_ready = 1'b0;
    pulse_arm();
    for (int i = 1; i <= 6; i++) begin
      commit(5'd6, DATA_W'(i), DATA_W'(32'h300 + 4 * i));
      if (i == 4) begin
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL full_done got %0d want 3", state); end
      end
    end
    checks++; if (count !== CW'(4) || dropped !== '0) begin
      errors++; $display("FAIL full_counts got c%0d d%0d want c4 d0", count, dropped); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rd_data !== DATA_W'(1 + k)) begin
        errors++; $display("FAIL full_drain%0d got %0d want %0d", k, rd_data, 1 + k); end
      pop_one();
    end
    pulse_arm();
    checks++; if (count !== '0 || state !== 2'd2) begin
      errors++; $display("FAIL full_rearm got c%0d s%0d want c0 s2", count, state); end
    commit(5'd6, 32'h77, 32'h400);
    checks++; if (rd_stamp !== '0 || rd_data !== 32'h77) begin
      errors++; $display("FAIL full_stamp0 got st%0d d%h want st0 d77", rd_stamp, rd_data); end
    mode = 1'b0;
  endtask

  task automatic test_push_pop_full();
    pulse_stop();
    mode = 1'b0; watch_mask = '1; rd_ready = 1'b0;
    pulse_arm();
    for (int i = 0; i < 4; i++) commit(5'd7, DATA_W'(32'h30 + i), DATA_W'(32'h500 + 4 * i));
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) commit(5'd7, DATA_W'(32'h40 + i), DATA_W'(32'h520 + 4 * i));
    rd_ready = 1'b0;
    checks++; if (count !== CW'(4) || dropped !== '0) begin
      errors++; $display("FAIL pp_counts got c%0d d%0d want c4 d0", count, dropped); end
    checks++; if (rd_data !== 32'h33 || {rd_stamp, rd_pc, rd_addr, rd_data} !== exp_q[0]) begin
      errors++; $display("FAIL pp_head got %h want %h", {rd_stamp, rd_pc, rd_addr, rd_data}, exp_q[0]); end
    commit(5'd0, 32'hDEAD, 32'h600);
    checks++; if (count !== CW'(4) || dropped !== '0 || rd_data !== 32'h33) begin
      errors++; $display("FAIL pp_zero got c%0d d%0d h%h want c4 d0 h33", count, dropped, rd_data); end
  endtask

  task automatic test_async_reset();
    pulse_stop();
    mode = 1'b0; watch_mask = '1; rd_ready = 1'b0;
    pulse_arm();
    for (int i = 0; i < 3; i++) commit(5'd9, DATA_W'(i + 1), DATA_W'(32'h700 + 4 * i));
    checks++; if (count !== CW'(3) || state !== 2'd2) begin
      errors++; $display("FAIL ar_pre got c%0d s%0d want c3 s2", count, state); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL ar_state got %0d want 0", state); end
    checks++; if (count !== '0) begin errors++; $display("FAIL ar_count got %0d want 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ar_rd_valid got %b want 0", rd_valid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    pulse_stop();
    for (int n = 0; n < 500; n++) begin
      arm  = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 29) == 0);
      if (arm && (m_state == 0 || m_state == 3)) begin
        mode       = 1'($urandom_range(0, 1));
        trig_en    = 1'($urandom_range(0, 1));
        trig_pc    = DATA_W'(4 * $urandom_range(1, 4));
        watch_mask = $urandom();
      end
      commit_valid = ($urandom_range(0, 9) < 7);
      reg_we       = ($urandom_range(0, 9) < 8);
      reg_waddr    = ADDR_W'($urandom_range(0, 31));
      reg_wdata    = $urandom();
      pc           = DATA_W'(4 * $urandom_range(1, 4));
      rd_ready     = ($urandom_range(0, 1) == 1);
      tick();
      checks++; if (state !== 2'(m_state)) begin
        errors++; $display("FAIL rnd_state@%0d got %0d want %0d", n, state, m_state); end
      checks++; if (count !== CW'(exp_q.size())) begin
        errors++; $display("FAIL rnd_count@%0d got %0d want %0d", n, count, exp_q.size()); end
      checks++; if (rd_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid@%0d got %b want %b", n, rd_valid, exp_q.size() != 0); end
      checks++; if (dropped !== m_dropped) begin
        errors++; $display("FAIL rnd_dropped@%0d got %0d want %0d", n, dropped, m_dropped); end
      if (exp_q.size() != 0) begin
        checks++; if ({rd_stamp, rd_pc, rd_addr, rd_data} !== exp_q[0]) begin
          errors++; $display("FAIL rnd_head@%0d got %h want %h", n, {rd_stamp, rd_pc, rd_addr, rd_data}, exp_q[0]); end
      end
    end
    arm = 1'b0; stop = 1'b0; commit_valid = 1'b0; reg_we = 1'b0; rd_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_immediate();
    test_trigger();
    test_wrap();
    test_stop_full();
    test_push_pop_full();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
Synthesizable debug trace unit for the single-cycle and pipelined MIPS cores. It records selected register-file writebacks and replaces per-cycle `$display` dumping with on-chip capture. Each retired write to a watched register is pushed into a circular buffer along with the PC and a cycle stamp. Capture can be immediate or PC-triggered. Entries drain through a first-word-fall-through valid/ready read port to a host or bench.

Parameters:
DEPTH, 16, buffer entries; power of two, at least 2.
DATA_W, 32, PC and register data width.
ADDR_W, 5, register address width; watch mask width is 2**ADDR_W.
CNT_W, 16, cycle-stamp and drop-counter width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
arm  in  1  start pulse; flushes buffer, clears stamp and dropped
stop  in  1  pulse; force DONE
mode  in  1  0 = wrap (overwrite oldest), 1 = stop when full
trig_en  in  1  0 = capture starts on arm; 1 = wait for trig_pc
trig_pc  in  DATA_W  trigger PC
watch_mask  in  2**ADDR_W  bit n = log writes to register n
commit_valid  in  1  an instruction retires this cycle
pc  in  DATA_W  PC of the retiring instruction
reg_we  in  1  register-file write enable
reg_waddr  in  ADDR_W  destination register
reg_wdata  in  DATA_W  write data
rd_valid  out  1  head entry available
rd_ready  in  1  consumer accepts head
rd_stamp  out  CNT_W  head cycle stamp
rd_pc  out  DATA_W  head PC
rd_addr  out  ADDR_W  head register
rd_data  out  DATA_W  head data
count  out  clog2(DEPTH)+1  occupied entries
state  out  2  0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = DONE
dropped  out  CNT_W  overwritten-entry count, saturating

Behaviour:
- Reset (asynchronous): state = IDLE; write pointer, read pointer, count, stamp and dropped = 0; rd_valid = 0. rd_* data outputs are don't-care while rd_valid = 0.
- Qualifying event (qe): commit_valid & reg_we & (reg_waddr != 0) & watch_mask[reg_waddr]. Writes to $zero are never logged.
- FSM transitions:
  - IDLE/DONE + arm: flush pointers, count, stamp and dropped. Go to ARMED if trig_en, else CAPTURE.
  - ARMED + commit_valid & pc == trig_pc: go to CAPTURE. A qe in that same cycle is captured.
  - CAPTURE + stop: go to DONE. A qe in the stop cycle is still captured.
  - CAPTURE, mode 1, push that makes count == DEPTH: go to DONE.
  - ARMED + stop: go to DONE with no capture.
  - arm in ARMED or CAPTURE is ignored.
- stamp:
  - Cleared on accepted arm, then increments every cycle in ARMED and CAPTURE.
  - Holds in IDLE and DONE.
  - Wraps modulo 2**CNT_W.
  - Entry field = stamp value in the push cycle.
- Push: in CAPTURE (or the trigger cycle) a qe writes {stamp, pc, reg_waddr, reg_wdata} at the write pointer on the clock edge. The entry is visible on rd_* the next cycle when the buffer was empty (1-cycle latency).
- Read port:
  - FWFT: rd_* = entry at the read pointer, combinational from storage; rd_valid = (count != 0).
  - Pop when rd_valid & rd_ready. Reads are allowed in every state, including DONE.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full, mode 0, push without pop: oldest entry overwritten, read pointer advances, count stays DEPTH. dropped increments and saturates at 2**CNT_W-1. rd_valid stays 1 while rd_* changes.
- Full, mode 0, push with pop: no drop.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows (pop ignored when empty).
- Reset asserted mid-capture: all state cleared immediately; buffer contents are lost.
- arm asserted in IDLE/DONE while a pop is requested: the flush wins and the pop is discarded.

Test Plan:
- Immediate capture: reset, mode=0, trig_en=0, watch_mask=0x0003_0000, arm. Commit writes $s0=0x5, $t0=0x9, $s1=0xA. Required: exactly 2 entries, ($s0, 0x5) then ($s1, 0xA), with stamps increasing and rd_ready=1 draining in order.
- PC trigger: trig_en=1, trig_pc=0x0000_0010, full mask. Writes occur at PC 0x4, 0x8 and 0x10. Required: first entry has pc 0x10, state goes ARMED then CAPTURE, and there are no earlier entries.
- Wrap overflow: DEPTH=4, mode=0, rd_ready=0, 6 qualifying writes with data 1..6. Required: count=4, dropped=2, drain yields 3, 4, 5, 6.
- Stop-when-full: DEPTH=4, mode=1, 6 writes. Required: state=DONE after the 4th write, entries 1..4 retained, dropped=0. Re-arm gives count=0 and stamp restarts at 0.
- Simultaneous push/pop at full in mode 0 with rd_ready=1: count stays 4 and dropped stays 0. A $zero write with mask bit 0 set produces no entry.
- Asynchronous reset mid-CAPTURE with count=3: outputs clear without waiting for clk; state=IDLE, count=0, rd_valid=0.
